// File: rtl/fir_out_serializer_pkg.sv
// Shared types and sizing helpers for the FIR output serializer.
// Define PARITY_EN to append an even-parity bit to every frame.
package fir_ser_p;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_e;

  function automatic int frame_bits(input int width);
`ifdef PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic int bitcnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/fir_out_serializer_if.sv
// Capture-side inputs and serial-link outputs of the serializer.
// master = word source / link reader, slave = serializer.
interface fir_out_serializer_if #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) ();

  logic [WIDTH-1:0]         in;
  logic                     in_valid;
  logic                     in_stb;
  logic                     sclk;
  logic                     sdata;
  logic                     frame;
  logic [$clog2(DEPTH):0]   fill;
  logic                     overflow;
  logic                     busy;

  modport master (
    output in,
    output in_valid,
    output in_stb,
    input  sclk,
    input  sdata,
    input  frame,
    input  fill,
    input  overflow,
    input  busy
  );

  modport slave (
    input  in,
    input  in_valid,
    input  in_stb,
    output sclk,
    output sdata,
    output frame,
    output fill,
    output overflow,
    output busy
  );

endinterface

// File: rtl/fir_out_serializer_fifo.sv
// Single-clock FIFO buffering captured filter words.
// A push while full is only accepted when a pop happens on the same edge.
module sample_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   fill_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    wr_d;
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    rd_d;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign fill_o  = cnt_q;
  assign data_o  = mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fir_out_serializer.sv
// Captures strobed filter words into a FIFO and shifts them out MSB-first
// on a framed sclk/sdata/frame link. PARITY_EN appends an even-parity bit.
module fir_out_serializer
  import fir_ser_p::*;
#(
  parameter int WIDTH   = 14,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 2,
  parameter int GAP     = 1
) (
  input  logic clk,
  input  logic rst,
  fir_out_serializer_if.slave bus
);

  localparam int FB      = frame_bits(WIDTH);
  localparam int BW      = bitcnt_w(WIDTH);
  localparam int GAP_CYC = GAP * 2 * CLK_DIV;
  localparam int CW      = $clog2(GAP_CYC + 1);
  localparam int FW      = $clog2(DEPTH) + 1;

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            phase_q;
  logic            phase_d;
  logic [BW-1:0]   bitcnt_q;
  logic [BW-1:0]   bitcnt_d;
  logic [FB-1:0]   shreg_q;
  logic [FB-1:0]   shreg_d;
  logic            sclk_q;
  logic            sclk_d;
  logic            sdata_q;
  logic            sdata_d;
  logic            frame_q;
  logic            frame_d;
  logic            ovf_q;
  logic            ovf_d;
  logic            busy_q;

  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [WIDTH-1:0] head;
  logic [FW-1:0]   fill;
  logic [FB-1:0]   load_word;
  logic            tick;
  logic            fall;
  logic            last;
  logic            gap_done;

  assign push = bus.in_stb & bus.in_valid;
  assign pop  = (state_q == S_LOAD);

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (bus.in),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .fill_o  (fill)
  );

`ifdef PARITY_EN
  assign load_word = {head, ^head};
`else
  assign load_word = head;
`endif

  assign tick     = (cnt_q == CW'(CLK_DIV - 1));
  assign fall     = (state_q == S_SHIFT) & tick & phase_q;
  assign last     = fall & (bitcnt_q == '0);
  assign gap_done = (state_q == S_GAP) &
                    (cnt_q == CW'(GAP_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!empty) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (last) state_d = S_GAP;
      S_GAP:   if (gap_done) state_d = empty ? S_IDLE : S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered link outputs and shift datapath.
  always_comb begin
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    sclk_d   = sclk_q;
    sdata_d  = sdata_q;
    frame_d  = frame_q;
    ovf_d    = ovf_q | (push & full & ~pop);
    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        phase_d = 1'b0;
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        frame_d = 1'b0;
      end
      S_LOAD: begin
        cnt_d    = '0;
        phase_d  = 1'b0;
        shreg_d  = load_word;
        bitcnt_d = BW'(FB - 1);
        sclk_d   = 1'b0;
        sdata_d  = load_word[FB-1];
        frame_d  = 1'b1;
      end
      S_SHIFT: begin
        if (!tick) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d   = '0;
          phase_d = ~phase_q;
          sclk_d  = ~phase_q;
          if (phase_q) begin
            if (bitcnt_q == '0) begin
              frame_d = 1'b0;
              sdata_d = 1'b0;
            end else begin
              shreg_d  = shreg_q << 1;
              sdata_d  = shreg_q[FB-2];
              bitcnt_d = bitcnt_q - BW'(1);
            end
          end
        end
      end
      S_GAP: begin
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        frame_d = 1'b0;
        cnt_d   = gap_done ? '0 : cnt_q + CW'(1);
      end
      default: begin
        cnt_d   = '0;
        phase_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      frame_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      frame_q  <= frame_d;
      ovf_q    <= ovf_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign bus.sclk     = sclk_q;
  assign bus.sdata    = sdata_q;
  assign bus.frame    = frame_q;
  assign bus.fill     = fill;
  assign bus.overflow = ovf_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_fir_out_serializer.sv
// Randomized and directed bench for fir_out_serializer.
// A link monitor rebuilds frames and compares them against a word queue.
module tb_fir_out_serializer;

  localparam int W  = 14;
  localparam int D  = 4;
  localparam int CD = 2;
  localparam int G  = 1;
`ifdef PARITY_EN
  localparam int FB = W + 1;
`else
  localparam int FB = W;
`endif
  localparam int FLEN = FB * 2 * CD;
  localparam int LOWB = 1 + G * 2 * CD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  fir_out_serializer_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fir_out_serializer #(
    .WIDTH   (W),
    .DEPTH   (D),
    .CLK_DIV (CD),
    .GAP     (G)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] got_q[$];
  int          len_q[$];
  int          rise_q[$];
  int          gap_q[$];
  int          rcyc_q[$];
  logic [31:0] exp_q[$];
  int          got_rd = 0;
  int          gap_rd = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [W-1:0] w);
`ifdef PARITY_EN
    return {17'b0, w, ^w};
`else
    return {18'b0, w};
`endif
  endfunction

  // Link monitor: bits are taken where sclk is first seen high in a frame.
  initial begin
    logic        in_fr = 1'b0;
    logic        fr_p = 1'b0;
    logic        sclk_p = 1'b0;
    logic        have_prev = 1'b0;
    logic [31:0] shw = '0;
    int          flen = 0;
    int          nr = 0;
    int          low = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_fr = 1'b0;
        fr_p = 1'b0;
        sclk_p = 1'b0;
        have_prev = 1'b0;
        low = 0;
      end else begin
        if (bus.frame && !fr_p) begin
          in_fr = 1'b1;
          flen = 0;
          nr = 0;
          shw = '0;
          rcyc_q.push_back(cyc);
          if (have_prev) gap_q.push_back(low);
        end
        if (bus.frame) begin
          flen++;
          if (bus.sclk && !sclk_p) begin
            nr++;
            shw = {shw[30:0], bus.sdata};
          end
        end
        if (!bus.frame && fr_p && in_fr) begin
          got_q.push_back(shw);
          len_q.push_back(flen);
          rise_q.push_back(nr);
          in_fr = 1'b0;
          have_prev = 1'b1;
          low = 0;
        end
        if (!bus.frame) low++;
        if (!bus.busy) have_prev = 1'b0;
        fr_p = bus.frame;
        sclk_p = bus.sclk;
      end
    end
  end

  task automatic strobe(input logic [W-1:0] w, input logic v);
    bus.in       = w;
    bus.in_valid = v;
    bus.in_stb   = 1'b1;
    @(negedge clk);
    bus.in_stb   = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((bus.busy || bus.fill != 0 || bus.frame) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_drain"}, 32'(k < 2000), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_nframes"}, got_q.size() - got_rd, exp_q.size());
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      chk({tag, "_word"}, got_q[got_rd], exp_q.pop_front());
      chk({tag, "_len"}, len_q[got_rd], FLEN);
      chk({tag, "_rises"}, rise_q[got_rd], FB);
      got_rd++;
    end
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  task automatic check_gaps(input string tag, input int n);
    chk({tag, "_ngaps"}, gap_q.size() - gap_rd, n);
    while (gap_rd < gap_q.size()) begin
      chk({tag, "_gap"}, gap_q[gap_rd], LOWB);
      gap_rd++;
    end
  endtask

  initial begin
    int base;
    int rc;
    int fmax;
    logic [W-1:0] w;
    logic v;

    bus.in = '0;
    bus.in_valid = 1'b0;
    bus.in_stb = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_sdata", bus.sdata, 0);
    chk("rst_frame", bus.frame, 0);
    chk("rst_fill", bus.fill, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // single word and capture-to-frame latency
    rc = rcyc_q.size();
    exp_q.push_back(exp_word(14'h2A5C));
    strobe(14'h2A5C, 1'b1);
    base = cyc;
    chk("single_fill", bus.fill, 1);
    @(negedge clk);
    chk("load_busy", bus.busy, 1);
    chk("load_frame", bus.frame, 0);
    @(negedge clk);
    chk("first_frame", bus.frame, 1);
    chk("first_msb", bus.sdata, exp_word(14'h2A5C) >> (FB - 1));
    drain("single");
    chk("single_rise", 32'(rcyc_q.size() > rc), 1);
    if (rcyc_q.size() > rc) chk("single_lat", rcyc_q[rc] - base, 2);
    check_frames("single");
    chk("single_busy", bus.busy, 0);
    chk("single_fill0", bus.fill, 0);
    gap_rd = gap_q.size();

    // valid gating
    for (int i = 0; i < 3; i++) begin
      strobe(14'(16'h1F00 + i), 1'b0);
      @(negedge clk);
    end
    exp_q.push_back(exp_word(14'h0001));
    strobe(14'h0001, 1'b1);
    drain("gate");
    check_frames("gate");
    chk("gate_ovf", bus.overflow, 0);

    // overflow on six consecutive strobes
    fmax = 0;
    for (int i = 1; i <= 6; i++) begin
      strobe(14'(i), 1'b1);
      if (int'(bus.fill) > fmax) fmax = int'(bus.fill);
      if (i == 5) chk("ovf_before", bus.overflow, 0);
      if (i == 6) chk("ovf_set", bus.overflow, 1);
      if (i <= 5) exp_q.push_back(exp_word(14'(i)));
    end
    repeat (4) begin
      @(negedge clk);
      if (int'(bus.fill) > fmax) fmax = int'(bus.fill);
    end
    chk("ovf_fill_peak", fmax, D);
    drain("ovf");
    check_frames("ovf");
    check_gaps("ovf", 4);
    chk("ovf_sticky", bus.overflow, 1);

    // back-to-back extremes
    exp_q.push_back(exp_word(14'h3FFF));
    exp_q.push_back(exp_word(14'h0000));
    strobe(14'h3FFF, 1'b1);
    strobe(14'h0000, 1'b1);
    drain("b2b");
    check_frames("b2b");
    check_gaps("b2b", 1);
    chk("b2b_ovf_sticky", bus.overflow, 1);

    // reset in the middle of a frame
    strobe(14'h1234, 1'b1);
    strobe(14'h0ABC, 1'b1);
    rc = 0;
    while (!bus.frame && rc < 20) begin
      @(negedge clk);
      rc++;
    end
    chk("mid_frame_seen", bus.frame, 1);
    repeat (20) @(negedge clk);
    chk("mid_fill", bus.fill, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_sclk", bus.sclk, 0);
    chk("mid_sdata", bus.sdata, 0);
    chk("mid_frame", bus.frame, 0);
    chk("mid_fill0", bus.fill, 0);
    chk("mid_ovf", bus.overflow, 0);
    chk("mid_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    got_rd = got_q.size();
    gap_rd = gap_q.size();
    exp_q.push_back(exp_word(14'h1555));
    strobe(14'h1555, 1'b1);
    drain("post_rst");
    check_frames("post_rst");
    chk("post_rst_ovf", bus.overflow, 0);

`ifdef PARITY_EN
    exp_q.push_back(exp_word(14'h0003));
    strobe(14'h0003, 1'b1);
    drain("par");
    chk("par_lsb", got_q[got_q.size()-1] & 32'h1, 0);
    check_frames("par");
`endif

    // randomized bursts that never exceed the buffer
    for (int b = 0; b < 20; b++) begin
      for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in = W'($urandom);
          bus.in_valid = 1'($urandom);
          @(negedge clk);
        end
        w = W'($urandom);
        v = ($urandom_range(0, 3) != 0);
        if (v) exp_q.push_back(exp_word(w));
        strobe(w, v);
      end
      drain("rand");
      check_frames("rand");
    end
    chk("rand_ovf", bus.overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
